ex_operand_skid: RTL and testbench

- Two-entry skid-buffered pipeline stage directly upstream of the execute-stage logic unit (16-bit XOR/AND/OR datapath).
- Captures operand pair plus op code from decode under a valid/ready handshake and presents them, registered, to the logic unit.
- Sustains 1 transfer/cycle with fully registered ready.
- Preserves order.
- Supports a synchronous flush on branch mispredict.

---
 rtl/ex_operand_skid.sv | 135 +++++++++++++
 tb/tb_ex_operand_skid.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_skid.sv
// Two-entry skid buffer feeding the execute-stage logic unit: operand pair plus
// op code are registered, order is preserved, and in_ready comes straight from a flop.
module ex_operand_skid #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [OPW-1:0]   out_op,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             ready_q;

  logic [WIDTH-1:0] main_a_p0;
  logic [WIDTH-1:0] main_b_p0;
  logic [OPW-1:0]   main_op_p0;
  logic [WIDTH-1:0] skid_a_p0;
  logic [WIDTH-1:0] skid_b_p0;
  logic [OPW-1:0]   skid_op_p0;

  logic             main_vld;
  logic             skid_vld;
  logic             accept;
  logic             consume;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign main_vld  = (state_q != EMPTY);
  assign skid_vld  = (state_q == FULL);
  assign accept    = in_valid & ready_q;
  assign consume   = main_vld & out_ready;

  assign in_ready  = ready_q;
  assign out_valid = main_vld;
  assign out_a     = main_a_p0;
  assign out_b     = main_b_p0;
  assign out_op    = main_op_p0;
  assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

  // Flush overrides any accept/consume in the same cycle; nothing is loaded.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ready is registered from the next state so it never depends on out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
    end
  end

  // Stage 0: main (output-facing) and skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_a_p0  <= '0;
      main_b_p0  <= '0;
      main_op_p0 <= '0;
      skid_a_p0  <= '0;
      skid_b_p0  <= '0;
      skid_op_p0 <= '0;
    end else begin
      if (load_main_in) begin
        main_a_p0  <= in_a;
        main_b_p0  <= in_b;
        main_op_p0 <= in_op;
      end else if (load_main_skid) begin
        main_a_p0  <= skid_a_p0;
        main_b_p0  <= skid_b_p0;
        main_op_p0 <= skid_op_p0;
      end
      if (load_skid) begin
        skid_a_p0  <= in_a;
        skid_b_p0  <= in_b;
        skid_op_p0 <= in_op;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_skid.sv
// Bench for ex_operand_skid: a capacity-2 FIFO queue models the stage; the
// monitor pops expected operand sets whenever the logic unit consumes.
module tb_ex_operand_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [2:0]  out_op;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_errors = 0;

  logic [34:0] exp_q[$];

  logic        prev_hold = 1'b0;
  logic [34:0] prev_data;

  ex_operand_skid #(.WIDTH(16), .OPW(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares status against model occupancy and pops on each consume.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      if (prev_hold && out_valid)
        chk("stable_data", 64'({out_a, out_b, out_op}), 64'(prev_data));
      if (flush) begin
        exp_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0)
          chk("out_data", 64'({out_a, out_b, out_op}), 64'(exp_q.pop_front()));
        prev_hold = out_valid && !out_ready;
        prev_data = {out_a, out_b, out_op};
      end
    end
  end

  // One cycle of stimulus: inputs change just after posedge; acceptance is
  // judged mid-cycle and the expected entry is queued at the accepting edge.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] op, input logic rdy, input logic fl);
    logic acc;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    acc = v && in_ready && !fl && !rst;
    @(posedge clk);
    if (acc) exp_q.push_back({a, b, op});
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 3'd0, rdy, 1'b0);
  endtask

  initial begin
    logic [15:0] a;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_a", 64'(out_a), 64'd0);
    rst = 1'b0;

    // Asynchronous reset while FULL
    step(1'b1, 16'h1234, 16'h00FF, 3'd1, 1'b0, 1'b0);
    step(1'b1, 16'hAAAA, 16'h5555, 3'd2, 1'b0, 1'b0);
    chk("full_occupancy", 64'(occupancy), 64'd2);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_out_a", 64'(out_a), 64'd0);
    chk("arst_out_b", 64'(out_b), 64'd0);
    chk("arst_out_op", 64'(out_op), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      a = 16'(i * 16'h1111);
      step(1'b1, a, ~a, 3'(i % 8), 1'b1, 1'b0);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      chk("stream_out_valid", 64'(out_valid), 64'd1);
      chk("stream_out_a", 64'(out_a), 64'(a));
      chk("stream_xor", 64'(out_a ^ out_b), 64'hFFFF);
    end
    idle(1'b1, 2);

    // Backpressure fill, blocked third set, then drain in order
    step(1'b1, 16'h0F0F, 16'hF0F0, 3'd1, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 16'h4321, 3'd2, 1'b0, 1'b0);
    chk("bp_occupancy", 64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 16'hDEAD, 16'h0000, 3'd3, 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 16'h0000, 3'd3, 1'b0, 1'b0);
    chk("bp_blocked_out_a", 64'(out_a), 64'h0F0F);
    step(1'b1, 16'hDEAD, 16'h0000, 3'd3, 1'b1, 1'b0);
    chk("bp_second_out_a", 64'(out_a), 64'h1234);
    step(1'b1, 16'hDEAD, 16'h0000, 3'd3, 1'b1, 1'b0);
    chk("bp_third_out_a", 64'(out_a), 64'hDEAD);
    idle(1'b1, 2);

    // Accept and consume in the same cycle while ONE
    step(1'b1, 16'h0001, 16'h0000, 3'd0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 16'h0000, 3'd0, 1'b1, 1'b0);
    chk("pass_out_a", 64'(out_a), 64'h0002);
    chk("pass_occupancy", 64'(occupancy), 64'd1);
    idle(1'b1, 2);

    // Flush beats accept and consume
    step(1'b1, 16'h1111, 16'h2222, 3'd1, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 16'h4444, 3'd2, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 16'hBEEF, 3'd7, 1'b1, 1'b1);
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    step(1'b1, 16'hBEEF, 16'hBEEF, 3'd7, 1'b1, 1'b1);
    chk("flush_drop_occupancy", 64'(occupancy), 64'd0);
    idle(1'b1, 3);

    // Output stability under backpressure with a busy upstream bus
    step(1'b1, 16'hC0DE, 16'h0BAD, 3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 1'b0, 1'b0);
    chk("hold_out_a", 64'(out_a), 64'hC0DE);
    chk("hold_out_b", 64'(out_b), 64'h0BAD);
    chk("hold_out_op", 64'(out_op), 64'd5);
    idle(1'b1, 3);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 3'($urandom),
           ($urandom % 3) != 0, ($urandom % 30) == 0);
    idle(1'b1, 4);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
